uart_system: RTL and testbench
==============================

Name: uart_system

Overview:
- Full-duplex 8N1 UART: byte-parallel host interface on one side, serial tx_out/rx_in lines on the other.
- Contains a shared baud-tick generator, a transmitter with a one-byte holding register, and a 16x-oversampling receiver with a one-byte output register.
- Top-level serial peripheral of the SoC, clocked from the system clock.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- baud, 115200, serial bit rate in bit/s.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_tx_data  in  1  load tx_data into the tx holding register.
- tx_data  in  8  byte to transmit.
- tx_enable  in  1  permits the transmitter to start frames.
- tx_out  out  1  serial transmit line; idle high.
- tx_empty  out  1  1 = tx holding register free.
- uld_rx_data  in  1  unload received byte to rx_data.
- rx_data  out  8  last unloaded received byte.
- rx_enable  in  1  enables the receiver.
- rx_in  in  1  serial receive line; asynchronous, idle high.
- rx_empty  out  1  1 = no unread received byte.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: tx_out=1, tx_empty=1, rx_empty=1, rx_data=0.
  - Internal: all counters, shift registers and FSMs return to idle.
- Tick generator:
  - RX_DIV = clk_freq/(baud*16), integer truncation; 27 at the defaults.
  - rx_tick is a 1-cycle pulse every RX_DIV clocks.
  - One bit period = 16 rx_ticks = 432 clk at the defaults.
  - The counter runs freely whenever reset is low.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX load:
  - Trigger: ld_tx_data=1 while tx_empty=1.
  - Effect: tx_data is latched and tx_empty goes to 0 on the next clock.
  - ld_tx_data while tx_empty=0 is ignored; the latched byte is unchanged.
  - ld_tx_data is level-sensitive, but only the first cycle loads, because tx_empty falls after it.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE -> START at a bit boundary when tx_empty=0 and tx_enable=1.
  - Each state lasts exactly 16 rx_ticks; DATA lasts 8 bit periods with bit index 0..7.
  - STOP -> IDLE: tx_empty returns to 1 at the end of the stop bit, and tx_out stays 1.
  - tx_enable is sampled only in IDLE. A frame in progress always completes, even if tx_enable drops mid-frame.
  - tx_out is registered.
- RX input synchronizer: rx_in passes through a 2-flop synchronizer.
- RX FSM, states IDLE, START, DATA, STOP:
  - Start detection: in IDLE, synchronized rx=0 on an rx_tick begins START.
  - START: rx is re-sampled at the 8th tick. If it is 1 (glitch), return to IDLE; otherwise continue.
  - DATA: 8 bits, each sampled at mid-bit (every 16 ticks after the start mid-point), shifted in LSB first.
  - STOP: sampled at mid-bit.
    - Stop bit = 1: byte is placed in the rx holding register and rx_empty goes to 0.
    - Stop bit = 0 (framing error): byte is discarded, rx_empty is unchanged.
  - Overrun: a valid byte arriving while rx_empty=0 overwrites the holding register; rx_empty stays 0.
  - rx_enable=0 forces the RX FSM to IDLE, aborting any frame in progress. The holding register and rx_empty are kept.
- RX unload:
  - uld_rx_data=1 copies the holding register to rx_data and sets rx_empty=1 on the next clock.
  - This happens even if rx_empty=1; the byte is stale in that case.
  - If the unload coincides with a frame completing, the new byte wins: rx_data gets the old holding value, the holding register gets the new byte, and rx_empty=0.
- Reset asserted mid-frame aborts both FSMs immediately; tx_out=1 on the next clock.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - OVERSAMPLE=16, DATA_BITS=8;
  - the RX_DIV computation function.
- Sub-modules: uart_tx and uart_rx, plus an inline tick counter in the top.
- A single sub-module, uart_rx, is also acceptable, with TX kept in the top.

Test Plan:
- Reset check: hold reset=1 for 5 clocks with rx_in=1 -> tx_out=1, tx_empty=1, rx_empty=1, rx_data=0.
- Load without enable: pulse ld_tx_data with tx_data=0xEF, tx_enable=0 -> tx_empty=0, tx_out stays 1 for 70 us.
- Transmit 0xEF: then set tx_enable=1 -> tx_out sends 0,1,1,1,1,0,1,1,1,1, each bit 432 clk; tx_empty=1 after the stop bit.
- Load while busy: ld_tx_data with 0xF2 while tx_empty=0 -> ignored, the frame still carries 0xEF.
- Loopback: rx_in driven by tx_out, rx_enable=1, send 0xF2 -> rx_empty=0 after the stop mid-point; uld_rx_data pulse gives rx_data=0xF2, rx_empty=1.
- Receiver robustness, three directed checks:
  - 4-clock low glitch on rx_in -> no byte received.
  - Frame 0x55 with stop=0 -> discarded.
  - rx_enable dropped mid-frame -> rx_empty stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: FSM state encoding, frame geometry
// and the oversampling divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_e;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  function automatic int calcRxDiv(input int clkFreq, input int baudRate);
    return clkFreq / (baudRate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, 16x oversampled mid-bit sampling,
// holding register and host-side output register.
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       enable_i,
  input  logic       rxIn_i,
  input  logic       uld_i,
  output logic [7:0] data_o,
  output logic       empty_o
);

  logic       sync1_q, sync2_q;
  uartState_e state_q, state_d;
  logic [3:0] tickCnt_q, tickCnt_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] data_q, data_d;
  logic       empty_q, empty_d;
  logic       frameDone;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      tickCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      hold_q    <= '0;
      data_q    <= '0;
      empty_q   <= 1'b1;
    end else begin
      sync1_q   <= rxIn_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      tickCnt_q <= tickCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      data_q    <= data_d;
      empty_q   <= empty_d;
    end
  end

  // START waits half a bit to land on the mid-point; later bits sample every full bit.
  always_comb begin
    state_d   = state_q;
    tickCnt_d = tickCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    data_d    = data_q;
    empty_d   = empty_q;
    frameDone = 1'b0;

    if (!enable_i) begin
      state_d   = IDLE;
      tickCnt_d = '0;
    end else if (tick_i) begin
      unique case (state_q)
        IDLE: begin
          tickCnt_d = '0;
          if (!sync2_q) begin
            state_d = START;
          end
        end
        START: begin
          if (tickCnt_q == 4'(OVERSAMPLE / 2 - 1)) begin
            tickCnt_d = '0;
            bitIdx_d  = '0;
            state_d   = sync2_q ? IDLE : DATA;
          end else begin
            tickCnt_d = tickCnt_q + 4'd1;
          end
        end
        DATA: begin
          if (tickCnt_q == 4'(OVERSAMPLE - 1)) begin
            tickCnt_d = '0;
            shift_d   = {sync2_q, shift_q[7:1]};
            if (bitIdx_q == 3'(DATA_BITS - 1)) begin
              state_d = STOP;
            end else begin
              bitIdx_d = bitIdx_q + 3'd1;
            end
          end else begin
            tickCnt_d = tickCnt_q + 4'd1;
          end
        end
        STOP: begin
          if (tickCnt_q == 4'(OVERSAMPLE - 1)) begin
            tickCnt_d = '0;
            state_d   = IDLE;
            frameDone = sync2_q;
          end else begin
            tickCnt_d = tickCnt_q + 4'd1;
          end
        end
      endcase
    end

    // A completing frame takes priority over an unload in the same cycle.
    if (uld_i) begin
      data_d  = hold_q;
      empty_d = 1'b1;
    end
    if (frameDone) begin
      hold_d  = shift_q;
      empty_d = 1'b0;
    end
  end

  assign data_o  = data_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding register and a bit-boundary aligned
// frame sequencer driving a registered serial line.
module uart_tx
  import uart_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       ld_i,
  input  logic [7:0] data_i,
  input  logic       enable_i,
  output logic       txOut_o,
  output logic       empty_o
);

  uartState_e state_q, state_d;
  logic [3:0] tickCnt_q, tickCnt_d;
  logic [2:0] bitIdx_q, bitIdx_d;
  logic [7:0] hold_q, hold_d;
  logic       txOut_q, txOut_d;
  logic       empty_q, empty_d;
  logic       boundary;
  logic [2:0] nextIdx;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      tickCnt_q <= '0;
      bitIdx_q  <= '0;
      hold_q    <= '0;
      txOut_q   <= 1'b1;
      empty_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tickCnt_q <= tickCnt_d;
      bitIdx_q  <= bitIdx_d;
      hold_q    <= hold_d;
      txOut_q   <= txOut_d;
      empty_q   <= empty_d;
    end
  end

  // The tick counter free-runs so every state change lands on a 16-tick bit boundary.
  always_comb begin
    state_d   = state_q;
    tickCnt_d = tickCnt_q;
    bitIdx_d  = bitIdx_q;
    hold_d    = hold_q;
    txOut_d   = txOut_q;
    empty_d   = empty_q;
    nextIdx   = bitIdx_q + 3'd1;
    boundary  = tick_i && (tickCnt_q == 4'(OVERSAMPLE - 1));

    if (tick_i) begin
      tickCnt_d = tickCnt_q + 4'd1;
    end

    if (ld_i && empty_q) begin
      hold_d  = data_i;
      empty_d = 1'b0;
    end

    if (boundary) begin
      unique case (state_q)
        IDLE: begin
          if (!empty_q && enable_i) begin
            state_d = START;
            txOut_d = 1'b0;
          end
        end
        START: begin
          state_d  = DATA;
          bitIdx_d = '0;
          txOut_d  = hold_q[0];
        end
        DATA: begin
          if (bitIdx_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
            txOut_d = 1'b1;
          end else begin
            bitIdx_d = nextIdx;
            txOut_d  = hold_q[nextIdx];
          end
        end
        STOP: begin
          state_d = IDLE;
          empty_d = 1'b1;
        end
      endcase
    end
  end

  assign txOut_o = txOut_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/uart_system.sv
// Full-duplex 8N1 UART top: shared 16x baud tick generator feeding the
// transmitter and receiver.
module uart_system
  import uart_pkg::*;
#(
  parameter int clk_freq = 50000000,
  parameter int baud     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_tx_data,
  input  logic [7:0] tx_data,
  input  logic       tx_enable,
  output logic       tx_out,
  output logic       tx_empty,
  input  logic       uld_rx_data,
  output logic [7:0] rx_data,
  input  logic       rx_enable,
  input  logic       rx_in,
  output logic       rx_empty
);

  localparam int RX_DIV = calcRxDiv(clk_freq, baud);
  localparam int CW     = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;

  logic [CW-1:0] divCnt_q, divCnt_d;
  logic          rxTick;

  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt_q <= '0;
    end else begin
      divCnt_q <= divCnt_d;
    end
  end

  always_comb begin
    rxTick   = (divCnt_q == CW'(RX_DIV - 1));
    divCnt_d = rxTick ? '0 : divCnt_q + 1'b1;
  end

  uart_tx u_tx (
    .clk_i    (clk),
    .reset_i  (reset),
    .tick_i   (rxTick),
    .ld_i     (ld_tx_data),
    .data_i   (tx_data),
    .enable_i (tx_enable),
    .txOut_o  (tx_out),
    .empty_o  (tx_empty)
  );

  uart_rx u_rx (
    .clk_i    (clk),
    .reset_i  (reset),
    .tick_i   (rxTick),
    .enable_i (rx_enable),
    .rxIn_i   (rx_in),
    .uld_i    (uld_rx_data),
    .data_o   (rx_data),
    .empty_o  (rx_empty)
  );

endmodule

// File: tb/tb_uart_system.sv
// Directed bench for uart_system at default parameters (432 clk per bit):
// TX framing, loopback reception, receiver robustness and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_system;

  localparam int BIT_CLKS = 432;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_tx_data;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_out;
  logic       tx_empty;
  logic       uld_rx_data;
  logic [7:0] rx_data;
  logic       rx_enable;
  logic       rx_in;
  logic       rx_empty;
  logic       loopback;
  logic       rxLine;

  int total = 0;
  int bad   = 0;

  assign rx_in = loopback ? tx_out : rxLine;

  uart_system dut (
    .clk         (clk),
    .reset       (reset),
    .ld_tx_data  (ld_tx_data),
    .tx_data     (tx_data),
    .tx_enable   (tx_enable),
    .tx_out      (tx_out),
    .tx_empty    (tx_empty),
    .uld_rx_data (uld_rx_data),
    .rx_data     (rx_data),
    .rx_enable   (rx_enable),
    .rx_in       (rx_in),
    .rx_empty    (rx_empty)
  );

  always #10 clk = ~clk;

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [7:0] data, input logic uld);
    ld_tx_data  = ld;
    tx_data     = data;
    uld_rx_data = uld;
    stepClock();
    ld_tx_data  = 1'b0;
    uld_rx_data = 1'b0;
  endtask

  task automatic driveBit(input logic b);
    rxLine = b;
    repeat (BIT_CLKS) stepClock();
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    logic [7:0] v;
    v = b;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(v[i]);
    driveBit(stopBit);
    rxLine = 1'b1;
  endtask

  initial begin
    int         waited;
    logic       sawLow;
    logic [9:0] expBits;

    reset       = 1'b1;
    ld_tx_data  = 1'b0;
    tx_data     = 8'h00;
    tx_enable   = 1'b0;
    uld_rx_data = 1'b0;
    rx_enable   = 1'b0;
    rxLine      = 1'b1;
    loopback    = 1'b0;

    repeat (5) stepClock();
    checkOutput("reset tx_out", 8'(tx_out), 8'h01);
    checkOutput("reset tx_empty", 8'(tx_empty), 8'h01);
    checkOutput("reset rx_empty", 8'(rx_empty), 8'h01);
    checkOutput("reset rx_data", rx_data, 8'h00);
    reset = 1'b0;
    stepClock();

    $display("[TB] load 0xEF with transmitter disabled");
    applyStimulus(1'b1, 8'hEF, 1'b0);
    checkOutput("load tx_empty", 8'(tx_empty), 8'h00);
    sawLow = 1'b0;
    repeat (3500) begin
      stepClock();
      if (tx_out !== 1'b1) sawLow = 1'b1;
    end
    checkOutput("disabled line idle", 8'(sawLow), 8'h00);

    $display("[TB] transmit 0xEF, attempt 0xF2 load mid-frame");
    tx_enable = 1'b1;
    waited = 0;
    while (tx_out !== 1'b0 && waited < 2 * BIT_CLKS) begin
      stepClock();
      waited++;
    end
    checkOutput("tx start seen", 8'(tx_out), 8'h00);
    repeat (BIT_CLKS / 2) stepClock();
    expBits = 10'b11_1101_1110;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("tx 0xEF bit %0d", k), 8'(tx_out), 8'(expBits[k]));
      if (k == 2) begin
        applyStimulus(1'b1, 8'hF2, 1'b0);
        checkOutput("busy load ignored", 8'(tx_empty), 8'h00);
        repeat (BIT_CLKS - 1) stepClock();
      end else if (k == 9) begin
        checkOutput("mid-stop tx_empty", 8'(tx_empty), 8'h00);
        repeat (BIT_CLKS) stepClock();
      end else begin
        repeat (BIT_CLKS) stepClock();
      end
    end
    checkOutput("post-frame tx_empty", 8'(tx_empty), 8'h01);
    checkOutput("post-frame tx_out", 8'(tx_out), 8'h01);

    $display("[TB] loopback 0xF2");
    rx_enable = 1'b1;
    loopback  = 1'b1;
    applyStimulus(1'b1, 8'hF2, 1'b0);
    waited = 0;
    while (rx_empty !== 1'b0 && waited < 12 * BIT_CLKS) begin
      stepClock();
      waited++;
    end
    checkOutput("loopback rx_empty", 8'(rx_empty), 8'h00);
    checkOutput("rx_data before unload", rx_data, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("loopback rx_data", rx_data, 8'hF2);
    checkOutput("unload rx_empty", 8'(rx_empty), 8'h01);
    waited = 0;
    while (tx_empty !== 1'b1 && waited < 2 * BIT_CLKS) begin
      stepClock();
      waited++;
    end
    checkOutput("loopback tx done", 8'(tx_empty), 8'h01);
    loopback = 1'b0;
    repeat (BIT_CLKS) stepClock();

    $display("[TB] receiver robustness");
    rxLine = 1'b0;
    repeat (4) stepClock();
    rxLine = 1'b1;
    repeat (2 * BIT_CLKS) stepClock();
    checkOutput("glitch ignored", 8'(rx_empty), 8'h01);

    sendFrame(8'h55, 1'b0);
    repeat (2 * BIT_CLKS) stepClock();
    checkOutput("framing error discarded", 8'(rx_empty), 8'h01);

    sendFrame(8'hA3, 1'b1);
    checkOutput("direct frame rx_empty", 8'(rx_empty), 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("direct frame rx_data", rx_data, 8'hA3);

    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b1);
    rx_enable = 1'b0;
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b1);
    rxLine = 1'b1;
    rx_enable = 1'b1;
    repeat (2 * BIT_CLKS) stepClock();
    checkOutput("aborted frame rx_empty", 8'(rx_empty), 8'h01);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("stale unload rx_data", rx_data, 8'hA3);
    checkOutput("stale unload rx_empty", 8'(rx_empty), 8'h01);

    sendFrame(8'h3C, 1'b1);
    sendFrame(8'hC5, 1'b1);
    checkOutput("overrun rx_empty", 8'(rx_empty), 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("overrun rx_data", rx_data, 8'hC5);

    $display("[TB] reset during transmit");
    applyStimulus(1'b1, 8'h00, 1'b0);
    waited = 0;
    while (tx_out !== 1'b0 && waited < 2 * BIT_CLKS) begin
      stepClock();
      waited++;
    end
    checkOutput("second tx start seen", 8'(tx_out), 8'h00);
    repeat (3 * BIT_CLKS) stepClock();
    checkOutput("mid-frame data low", 8'(tx_out), 8'h00);
    reset = 1'b1;
    stepClock();
    checkOutput("reset abort tx_out", 8'(tx_out), 8'h01);
    checkOutput("reset abort tx_empty", 8'(tx_empty), 8'h01);
    checkOutput("reset abort rx_data", rx_data, 8'h00);
    reset = 1'b0;
    repeat (2 * BIT_CLKS) stepClock();
    checkOutput("idle after reset", 8'(tx_out), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
